// File: rtl/text_glyph_renderer_if.sv
// Memory-side bus of text_glyph_renderer: text buffer read port and font ROM port.
// The renderer drives addresses (master); the buffer/ROM wrapper returns data (slave).
interface text_glyph_renderer_if #(
    parameter int unsigned TEXT_AW = 13
);
    logic [TEXT_AW-1:0] txt_addr;
    logic [15:0]        txt_data;
    logic [10:0]        font_ad;
    logic [7:0]         font_dout;

    modport master (
        output txt_addr,
        output font_ad,
        input  txt_data,
        input  font_dout
    );

    modport slave (
        input  txt_addr,
        input  font_ad,
        output txt_data,
        output font_dout
    );
endinterface

// File: rtl/text_glyph_renderer.sv
// 8x8 character-cell renderer: text buffer -> font ROM -> CGA palette -> RGB888, 6-cycle latency.
// Optional blinking block cursor is built only when TEXT_CURSOR_EN is defined.
module text_glyph_renderer #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned TEXT_AW      = 13,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              px_x,
    input  logic [9:0]              px_y,
    input  logic                    de_in,
    input  logic                    hs_in,
    input  logic                    vs_in,
    input  logic [6:0]              cur_col,
    input  logic [5:0]              cur_row,
    input  logic                    cur_en,
    output logic [23:0]             rgb,
    output logic                    de_out,
    output logic                    hs_out,
    output logic                    vs_out,
    text_glyph_renderer_if.master   mem
);

    localparam int unsigned SYNC_DLY = 5;

    if (COLS * ROWS > (64'd1 << TEXT_AW)) begin : g_size_check
        $error("text_glyph_renderer: COLS*ROWS does not fit in TEXT_AW address bits");
    end

    // Per-pixel sideband that travels alongside the font ROM access
    typedef struct packed {
        logic [7:0] attr;
        logic [2:0] gcol;
        logic       hit;
    } cell_t;

    logic [TEXT_AW-1:0] addr_c;
    logic               hit_c;

    logic [TEXT_AW-1:0] txt_addr_q;
    logic [10:0]        font_ad_q;
    logic [2:0]         gcol1, gcol2;
    logic [2:0]         grow1, grow2;
    logic               hit1, hit2;
    cell_t              c3, c4, c5;
    logic [SYNC_DLY-1:0] de_d, hs_d, vs_d;

    logic               pix_bit_c;
    logic [3:0]         index_c;

    assign addr_c = TEXT_AW'(px_y[9:3]) * TEXT_AW'(COLS) + TEXT_AW'(px_x[9:3]);

`ifdef TEXT_CURSOR_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] frame_cnt;
    logic               blink_phase;
    logic               vs_prev;

    // Frame counter advances on vsync rising edges; phase flips on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
            vs_prev     <= 1'b0;
        end else begin
            vs_prev <= vs_in;
            if (vs_in && !vs_prev) begin
                if (frame_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + BLINK_W'(1);
                end
            end
        end
    end

    assign hit_c = cur_en && blink_phase
                && (px_x[9:3] == cur_col)
                && (px_y[9:3] == {1'b0, cur_row});
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_col, cur_row, cur_en, BLINK_FRAMES[0]};
    assign hit_c         = 1'b0;
`endif

    // Address/font pipeline: stage 1 addresses the buffer, stage 3 addresses the ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txt_addr_q <= '0;
            gcol1      <= '0;
            grow1      <= '0;
            hit1       <= 1'b0;
            gcol2      <= '0;
            grow2      <= '0;
            hit2       <= 1'b0;
            font_ad_q  <= '0;
            c3         <= '0;
            c4         <= '0;
            c5         <= '0;
        end else begin
            if (de_in) begin
                txt_addr_q <= addr_c;
            end
            gcol1     <= px_x[2:0];
            grow1     <= px_y[2:0];
            hit1      <= hit_c;
            gcol2     <= gcol1;
            grow2     <= grow1;
            hit2      <= hit1;
            font_ad_q <= {mem.txt_data[7:0], grow2};
            c3        <= '{attr: mem.txt_data[15:8], gcol: gcol2, hit: hit2};
            c4        <= c3;
            c5        <= c4;
        end
    end

    assign mem.txt_addr = txt_addr_q;
    assign mem.font_ad  = font_ad_q;

    // Sync/enable delay line matched to the pixel path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            de_d <= {de_d[SYNC_DLY-2:0], de_in};
            hs_d <= {hs_d[SYNC_DLY-2:0], hs_in};
            vs_d <= {vs_d[SYNC_DLY-2:0], vs_in};
        end
    end

    function automatic logic [23:0] cga_color(input logic [3:0] idx);
        logic [23:0] c;
        c = 24'h000000;
        case (idx)
            4'd0:  c = 24'h000000;
            4'd1:  c = 24'h0000AA;
            4'd2:  c = 24'h00AA00;
            4'd3:  c = 24'h00AAAA;
            4'd4:  c = 24'hAA0000;
            4'd5:  c = 24'hAA00AA;
            4'd6:  c = 24'hAA5500;
            4'd7:  c = 24'hAAAAAA;
            4'd8:  c = 24'h555555;
            4'd9:  c = 24'h5555FF;
            4'd10: c = 24'h55FF55;
            4'd11: c = 24'h55FFFF;
            4'd12: c = 24'hFF5555;
            4'd13: c = 24'hFF55FF;
            4'd14: c = 24'hFFFF55;
            4'd15: c = 24'hFFFFFF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Bit 7 is the leftmost pixel; the cursor swaps fg/bg by inverting the bit
    assign pix_bit_c = mem.font_dout[3'd7 - c5.gcol];
    assign index_c   = (pix_bit_c ^ c5.hit) ? c5.attr[3:0] : c5.attr[7:4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb    <= '0;
            de_out <= 1'b0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            rgb    <= de_d[SYNC_DLY-1] ? cga_color(index_c) : 24'h000000;
            de_out <= de_d[SYNC_DLY-1];
            hs_out <= hs_d[SYNC_DLY-1];
            vs_out <= vs_d[SYNC_DLY-1];
        end
    end

    logic unused_rows;
    assign unused_rows = ROWS[0];

endmodule
